// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int SEQ_DIV_MAX_WIDTH = 32;
  localparam int SEQ_DIV_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    // Borrow out of the extra MSB means the divisor did not fit.
    q_bit_o = ~trial[WIDTH+1];
    rem_o   = q_bit_o ? trial[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to add the signed_op port and the FIX sign-correction state.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept, fix_go;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             unused_rem_msb;

`ifdef SEQ_DIV_SIGNED_EN
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  assign a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
  assign fix_go = sgn_q;
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign fix_go = 1'b0;
`endif

  assign accept         = start && (state_q == IDLE || state_q == DONE);
  // The restored remainder is always below the divisor, so its top bit stays 0.
  assign unused_rem_msb = rem_q[WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q[WIDTH-1:0]),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (b == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      RUN:     if (cnt_q == '0) state_d = fix_go ? FIX : DONE;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    sgn_d  = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    if (accept) begin
      cnt_d = CW'(WIDTH - 1);
      dvs_d = b_mag;
      if (b == '0) begin
        quo_d = '1;
        rem_d = {1'b0, a};
        dbz_d = 1'b1;
      end else begin
        // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
        quo_d = a_mag;
        rem_d = '0;
        dbz_d = 1'b0;
      end
`ifdef SEQ_DIV_SIGNED_EN
      sgn_d  = signed_op;
      qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
      rneg_d = a[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      quo_d = {quo_q[WIDTH-2:0], step_q};
      rem_d = step_rem;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
`ifdef SEQ_DIV_SIGNED_EN
    else if (state_q == FIX) begin
      if (qneg_q) quo_d = -quo_q;
      if (rneg_q) rem_d = {1'b0, -rem_q[WIDTH-1:0]};
    end
`endif
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == FIX);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q[WIDTH-1:0];
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an 8-bit and a 16-bit instance side by side.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, dbz8, busy16, done16, dbz16;
  logic [7:0]  q8o, r8o;
  logic [15:0] q16o, r16o;
`ifdef SEQ_DIV_SIGNED_EN
  logic        sgn8 = 1'b0, sgn16 = 1'b0;
`endif

  exp_t        sb8[$], sb16[$];
  exp_t        e8, e16;
  int          checks = 0, errors = 0;
  logic [31:0] av, bv;
  int          n;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op(sgn8),
`endif
    .busy(busy8), .done(done8), .quotient(q8o), .remainder(r8o), .div_by_zero(dbz8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op(sgn16),
`endif
    .busy(busy16), .done(done16), .quotient(q16o), .remainder(r16o), .div_by_zero(dbz16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (sb8.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done8: got done=1 expected no pending op");
      end else begin
        e8 = sb8.pop_front();
        chk("quot8", 32'(q8o), e8.q);
        chk("rem8",  32'(r8o), e8.r);
        chk("dbz8",  32'(dbz8), 32'(e8.z));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (sb16.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done16: got done=1 expected no pending op");
      end else begin
        e16 = sb16.pop_front();
        chk("quot16", 32'(q16o), e16.q);
        chk("rem16",  32'(r16o), e16.r);
        chk("dbz16",  32'(dbz16), 32'(e16.z));
      end
    end
  end

  // Issue one op, push its expectation, then check latency (edges after the
  // accepting edge until done is visible), busy while running and the pulse width.
  task automatic run_op(input bit w16, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int exp_lat, input string tag);
    exp_t e;
    int   lat;
    bit   busy_ok;
    logic d, bz;
    @(negedge clk);
    e.q = eq; e.r = er; e.z = ez;
    if (w16) begin
      a16 = a_v[15:0]; b16 = b_v[15:0]; start16 = 1'b1; sb16.push_back(e);
    end else begin
      a8 = a_v[7:0]; b8 = b_v[7:0]; start8 = 1'b1; sb8.push_back(e);
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    lat = -1; busy_ok = 1'b1; bz = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      d  = w16 ? done16 : done8;
      bz = w16 ? busy16 : busy8;
      if (d) begin lat = k; break; end
      if (!bz) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bz), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(w16 ? done16 : done8), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot8", 32'(q8o), 32'd0);
    chk("rst_rem8",  32'(r8o), 32'd0);
    chk("rst_dbz8",  32'(dbz8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_quot16", 32'(q16o), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    rst_n = 1'b1;

    run_op(0, 200, 7, 28, 4, 0, 8, "u200_7");
    run_op(0, 13, 0, 'hFF, 13, 1, 0, "div0_8");
    run_op(0, 13, 13, 1, 0, 0, 8, "u13_13");
    run_op(0, 255, 255, 1, 0, 0, 8, "u255_255");
    run_op(0, 5, 200, 0, 5, 0, 8, "u5_200");
    run_op(0, 255, 1, 255, 0, 0, 8, "u255_1");

    // Start pulsed mid-run is ignored; start held in DONE launches back-to-back.
    @(negedge clk);
    a8 = 100; b8 = 3; start8 = 1'b1;
    e8.q = 33; e8.r = 1; e8.z = 1'b0; sb8.push_back(e8);
    @(posedge clk); #1; start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1; a8 = 50; b8 = 5; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    n = 3;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("ign_latency", n, 8);
    e8.q = 10; e8.r = 0; e8.z = 1'b0; sb8.push_back(e8);
    start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_done_low", 32'(done8), 32'd0);
    n = 0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_latency", n, 8);
    @(posedge clk); #1;

    // Reset mid-operation drops the op with no done pulse.
    @(negedge clk);
    a8 = 255; b8 = 2; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_quot", 32'(q8o), 32'd0);
    chk("midrst_rem",  32'(r8o), 32'd0);
    chk("midrst_dbz",  32'(dbz8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    run_op(0, 9, 4, 2, 1, 0, 8, "u9_4");

`ifdef SEQ_DIV_SIGNED_EN
    sgn8 = 1'b1;
    run_op(0, 'hF9, 'h02, 'hFD, 'hFF, 0, 9, "s_m7_2");
    run_op(0, 'h07, 'hFE, 'hFD, 'h01, 0, 9, "s_7_m2");
    run_op(0, 'h80, 'hFF, 'h80, 'h00, 0, 9, "s_min_m1");
    run_op(0, 'hF9, 'h00, 'hFF, 'hF9, 1, 0, "s_div0");
    sgn8 = 1'b0;
    run_op(0, 'hF9, 'h02, 124, 1, 0, 8, "u249_2");
`endif

    run_op(1, 65535, 1, 65535, 0, 0, 16, "w16_max_1");
    run_op(1, 1000, 65535, 0, 1000, 0, 16, "w16_small");
    run_op(1, 40000, 0, 'hFFFF, 40000, 1, 0, "w16_div0");
    run_op(1, 50000, 7, 7142, 6, 0, 16, "w16_50000_7");

    for (int i = 0; i < 6; i++) begin
      av = $urandom_range(0, 255);
      bv = $urandom_range(1, 255);
      run_op(0, av, bv, av / bv, av % bv, 0, 8, "rnd8");
    end
    for (int i = 0; i < 6; i++) begin
      av = $urandom_range(0, 65535);
      bv = $urandom_range(1, 65535);
      run_op(1, av, bv, av / bv, av % bv, 0, 16, "rnd16");
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb8.size() + sb16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
